// File: rtl/stage4_accum_part_pkg.sv
// Shared widths and output range limits for the stage-4 trapezoid accumulator.
package stage4_pkg;
   localparam int D_W    = 26;
   localparam int M_W    = 16;
   localparam int P_W    = 40;
   localparam int R_W    = 44;
   localparam int S_W    = 56;
   localparam int SH_W   = 5;
   localparam int WARMUP = 32;

   localparam logic signed [D_W-1:0] D_MAX = {1'b0, {(D_W-1){1'b1}}};
   localparam logic signed [D_W-1:0] D_MIN = {1'b1, {(D_W-1){1'b0}}};
endpackage

// File: rtl/stage4_accum_part_if.sv
// Sample bus between the stage-3 comb, the stage-4 accumulator and its consumer.
interface stage4_accum_part_if;
   import stage4_pkg::*;

   logic signed [D_W-1:0]  DATAIN;
   logic        [M_W-1:0]  M_COEF;
   logic        [SH_W-1:0] SHIFT;
   logic signed [D_W-1:0]  DATAOUT;
   logic                   DATAOUT_VALID;
   logic                   OVF;

   modport master (
      output DATAIN, M_COEF, SHIFT,
      input  DATAOUT, DATAOUT_VALID, OVF
   );

   modport slave (
      input  DATAIN, M_COEF, SHIFT,
      output DATAOUT, DATAOUT_VALID, OVF
   );
endinterface

// File: rtl/stage4_accum_part_fit.sv
// Normalizing shift and range fit of the second accumulator onto the output width.
// Build with STAGE4_SAT_EN defined to clamp out-of-range values instead of wrapping.
module stage4_fit
   import stage4_pkg::*;
(
   input  logic signed [S_W-1:0]  s_val,
   input  logic        [SH_W-1:0] shift,
   output logic signed [D_W-1:0]  fitted,
   output logic                   ovf_hit
);
   localparam logic signed [S_W-1:0] HI = S_W'(D_MAX);
   localparam logic signed [S_W-1:0] LO = S_W'(D_MIN);

   logic signed [S_W-1:0] shifted;

   always_comb begin
      shifted = s_val >>> shift;
      ovf_hit = (shifted > HI) || (shifted < LO);
      fitted  = shifted[D_W-1:0];
`ifdef STAGE4_SAT_EN
      if (ovf_hit) begin
         fitted = shifted[S_W-1] ? D_MIN : D_MAX;
      end
`endif
   end
endmodule

// File: rtl/stage4_accum_part.sv
// Pole-zero corrected double accumulator producing the shaped trapezoid output.
// Optional clamp on overflow via STAGE4_SAT_EN (see stage4_fit); default build wraps.
module stage4_accum_part
   import stage4_pkg::*;
(
   input  logic               SYS_CLK,
   input  logic               RESET_N,
   input  logic               CLR,
   stage4_accum_part_if.slave bus
);
   localparam int CNT_W = $clog2(WARMUP + 1);
   localparam int PR_W  = D_W + M_W + 1;

   logic signed [P_W-1:0]  p_reg;
   logic signed [D_W-1:0]  d1_reg;
   logic signed [R_W-1:0]  r_reg;
   logic signed [S_W-1:0]  s_reg;
   logic        [CNT_W-1:0] cnt_reg;

   logic signed [PR_W-1:0] prod;
   logic signed [D_W-1:0]  fit_val;
   logic                   ovf_hit;

   // M is unsigned, so it gets a zero sign bit before the signed multiply
   assign prod = PR_W'(d1_reg) * PR_W'($signed({1'b0, bus.M_COEF}));

   stage4_fit u_fit (
      .s_val   (s_reg),
      .shift   (bus.SHIFT),
      .fitted  (fit_val),
      .ovf_hit (ovf_hit)
   );

   always_ff @(posedge SYS_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         p_reg             <= '0;
         d1_reg            <= '0;
         r_reg             <= '0;
         s_reg             <= '0;
         cnt_reg           <= '0;
         bus.DATAOUT       <= '0;
         bus.DATAOUT_VALID <= 1'b0;
         bus.OVF           <= 1'b0;
      end else if (CLR) begin
         p_reg             <= '0;
         d1_reg            <= '0;
         r_reg             <= '0;
         s_reg             <= '0;
         cnt_reg           <= '0;
         bus.DATAOUT       <= '0;
         bus.DATAOUT_VALID <= 1'b0;
         bus.OVF           <= 1'b0;
      end else begin
         d1_reg      <= bus.DATAIN;
         p_reg       <= p_reg + P_W'(bus.DATAIN);
         r_reg       <= R_W'(p_reg) + R_W'(prod);
         s_reg       <= s_reg + S_W'(r_reg);
         bus.DATAOUT <= fit_val;
         if (ovf_hit) begin
            bus.OVF <= 1'b1;
         end
         // counter saturates at WARMUP; valid rises on the WARMUP-th edge
         if (cnt_reg < CNT_W'(WARMUP)) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (cnt_reg == CNT_W'(WARMUP - 1)) begin
            bus.DATAOUT_VALID <= 1'b1;
         end
      end
   end
endmodule

// File: doc/stage4_accum_part.md
Name: stage4_accum_part

Overview:
Downstream neighbour of the stage-3 comb (27-deep delay difference) in the trapezoidal filter chain. Consumes the 26-bit comb difference d(n) every SYS_CLK and performs the pole-zero-corrected double accumulation:
- p(n) = p(n-1) + d(n)
- r(n) = p(n) + M*d(n)
- s(n) = s(n-1) + r(n)

Emits the normalized trapezoid s(n) >>> SHIFT as a 26-bit shaped output, with a warm-up valid flag and a sticky overflow flag.

Parameters:
- D_W, 26: input/output sample width (signed).
- M_W, 16: pole-zero coefficient width (unsigned).
- P_W, 40: first accumulator width (signed).
- R_W, 44: corrected-sum width (signed).
- S_W, 56: second accumulator width (signed).
- WARMUP, 32: cycles after reset/CLR before DATAOUT_VALID asserts; covers the comb depth plus the pipeline.

Ports:
- SYS_CLK, input, 1: single system clock, rising edge.
- RESET_N, input, 1: asynchronous active-low reset.
- CLR, input, 1: synchronous clear of all accumulators, pipeline and warm-up counter.
- DATAIN, input, D_W: signed comb difference d(n) from stage 3, new sample every cycle.
- M_COEF, input, M_W: unsigned pole-zero coefficient M.
- SHIFT, input, 5: arithmetic right-shift normalization, 0..31.
- DATAOUT, output reg, D_W: signed shaped output.
- DATAOUT_VALID, output reg, 1: high once warm-up has completed.
- OVF, output reg, 1: sticky flag for output range violation.

Behaviour:
- Reset (RESET_N low, async): all internal registers, DATAOUT, DATAOUT_VALID and OVF go to 0. The warm-up counter goes to 0.
- Pipeline, sample taken at edge k:
  - Stage A, edge k: d1 <= DATAIN; p <= p + sext(DATAIN).
  - Stage B, edge k+1: d2 <= d1; r <= sext(p) + d1 * $signed({1'b0,M_COEF}). The full product is sign-extended to R_W.
  - Stage C, edge k+2: s <= s + sext(r).
  - Stage D, edge k+3: DATAOUT <= fit(s >>> SHIFT).
  - Latency is 4 registers.
- Internal accumulators p and s wrap in two's complement. They are never saturated.
- M_COEF and SHIFT are not registered. Each is used combinationally in the stage that consumes it, so a change affects the sample currently in that stage.
- fit():
  - If the shifted value lies within [-2^(D_W-1), 2^(D_W-1)-1], it passes unchanged.
  - Otherwise, OVF <= 1. The output value is set by the optional feature below.
- OVF stays set until reset or CLR.
- Warm-up counter:
  - Increments each cycle while below WARMUP.
  - DATAOUT_VALID <= 1 on the edge where the counter reaches WARMUP-1 → 1, i.e. high on the WARMUP-th edge after reset release/CLR.
  - Stays high afterwards.
- CLR, synchronous:
  - Zeroes p, d1, d2, r, s, DATAOUT, OVF, the counter and DATAOUT_VALID.
  - CLR has priority over data. The DATAIN sampled on a CLR edge is discarded.
  - The first sample accumulated is the one at edge CLR+1.
- Reset mid-operation: asynchronously drops all state regardless of pipeline contents. There is no partial flush.
- Simultaneous CLR and overflow: CLR wins, so OVF = 0.

Optional Feature:
- Macro STAGE4_SAT_EN.
- Defined: an out-of-range output clamps to +2^(D_W-1)-1 or -2^(D_W-1) according to the sign of the shifted s.
- Undefined: the output is the low D_W bits of the shifted s (wrap).
- OVF behaviour is identical in both builds.

Decomposition:
- Package stage4_pkg holds D_W/M_W/P_W/R_W/S_W defaults and the constants D_MAX = 2^(D_W-1)-1 and D_MIN = -2^(D_W-1).
- One sub-module, stage4_fit: purely combinational shift/range-check/clamp-or-wrap, with outputs fitted value and ovf_hit. Instantiated once at stage D.
- Accumulator stages stay in the top.

Test Plan:
- Impulse: M=0, SHIFT=0, DATAIN=1 at edge 0, then 0 → DATAOUT = 1, 2, 3, … from edge 3; OVF=0.
- Pole-zero: M=2, SHIFT=0, DATAIN=1 at edge 0 → DATAOUT = 3 at edge 3, then 4, 5, 6 …
- Shift: M=0, SHIFT=2, DATAIN=8 at edge 0 → DATAOUT = 2, 4, 6 … from edge 3.
- Overflow: M=0, SHIFT=0, DATAIN=16777216 once → DATAOUT = 16777216 at edge 3; at edge 4, the SAT_EN build gives 33554431 and the wrap build gives -33554432; OVF=1 from edge 4 and stays set.
- CLR mid-run: assert CLR one cycle during the overflow test → DATAOUT=0, OVF=0, VALID=0 on the next edge; VALID re-asserts exactly 32 edges after CLR.
- Async reset mid-pipeline: pulse RESET_N low between edges with nonzero p/s → all outputs 0 immediately; the next impulse reproduces the first test's sequence exactly.
